// File: rtl/pll_sup_pkg.sv
// Shared definitions for the PLL lock supervisor: state encoding and counter sizing.
package pll_sup_pkg;

  localparam logic [2:0] ST_RESET     = 3'd0;
  localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
  localparam logic [2:0] ST_RELEASE   = 3'd2;
  localparam logic [2:0] ST_RUN       = 3'd3;

  typedef enum logic [2:0] {
    S_RESET     = ST_RESET,
    S_WAIT_LOCK = ST_WAIT_LOCK,
    S_RELEASE   = ST_RELEASE,
    S_RUN       = ST_RUN
  } sup_state_e;

  // Bits needed to hold values 0..max_val inclusive.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/lock_filter.sv
// Two-flop synchroniser for the raw PLL lock plus consecutive-sample filters.
// lock_good fires on the HI_LEN-th consecutive synced-high sample while hi_en is set;
// lock_lost fires on the LO_LEN-th consecutive synced-low sample while lo_en is set.
// Both are combinational strobes consumed by the supervisor's registered FSM.
module lock_filter #(
  parameter int HI_LEN = 1024,
  parameter int LO_LEN = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pll_lock,
  input  logic hi_en,
  input  logic lo_en,
  output logic lock_good,
  output logic lock_lost
);
  import pll_sup_pkg::*;

  localparam int HW = cnt_width(HI_LEN);
  localparam int LW = cnt_width(LO_LEN);
  localparam logic [HW-1:0] HI_LAST = HW'(HI_LEN - 1);
  localparam logic [HW-1:0] HI_MAX  = HW'(HI_LEN);
  localparam logic [LW-1:0] LO_LAST = LW'(LO_LEN - 1);
  localparam logic [LW-1:0] LO_MAX  = LW'(LO_LEN);

  logic          sync_1;
  logic          sync_2;
  logic [HW-1:0] hi_cnt;
  logic [LW-1:0] lo_cnt;

  // Bring the asynchronous lock into the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
    end else begin
      sync_1 <= pll_lock;
      sync_2 <= sync_1;
    end
  end

  // Count consecutive synced-high samples; any low sample or disable clears the run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_cnt <= '0;
    end else if (!hi_en || !sync_2) begin
      hi_cnt <= '0;
    end else if (hi_cnt != HI_MAX) begin
      hi_cnt <= hi_cnt + 1'b1;
    end
  end

  // Count consecutive synced-low samples; any high sample or disable clears the run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_cnt <= '0;
    end else if (!lo_en || sync_2) begin
      lo_cnt <= '0;
    end else if (lo_cnt != LO_MAX) begin
      lo_cnt <= lo_cnt + 1'b1;
    end
  end

  assign lock_good = hi_en &&  sync_2 && (hi_cnt == HI_LAST);
  assign lock_lost = lo_en && !sync_2 && (lo_cnt == LO_LAST);

endmodule

// File: rtl/pll_lock_supervisor.sv
// Sequences PLL reset, waits for a filtered lock, then releases downstream channel
// resets one at a time. Lock loss, lock timeout or a restart request sends it back
// to RESET. All outputs come straight from flops; state is exposed for debug.
module pll_lock_supervisor #(
  parameter int NUM_CH       = 5,
  parameter int RST_CYCLES   = 64,
  parameter int LOCK_FILTER  = 1024,
  parameter int LOCK_TIMEOUT = 500000,
  parameter int LOSS_FILTER  = 4,
  parameter int STAGGER      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pll_lock,
  input  logic              restart,
  output logic              pll_rst,
  output logic [NUM_CH-1:0] ch_rst_n,
  output logic              all_ready,
  output logic [2:0]        state,
  output logic [7:0]        relock_cnt
);
  import pll_sup_pkg::*;

  // One cycle counter serves RESET width, WAIT_LOCK timeout and RELEASE stagger.
  localparam int REL_LEN = NUM_CH * STAGGER;
  localparam int MAX_AB  = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int CNT_MAX = (MAX_AB > REL_LEN) ? MAX_AB : REL_LEN;
  localparam int CW      = cnt_width(CNT_MAX);
  localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] REL_DONE = CW'(REL_LEN);

  sup_state_e        state_q;
  sup_state_e        state_nxt;
  logic [CW-1:0]     cyc_cnt;
  logic [CW-1:0]     cnt_nxt;
  logic [NUM_CH-1:0] ch_nxt;
  logic              lock_good;
  logic              lock_lost;
  logic              timeout;
  logic              relock_inc;

  lock_filter #(
    .HI_LEN (LOCK_FILTER),
    .LO_LEN (LOSS_FILTER)
  ) u_lock_filter (
    .clk       (clk),
    .rst_n     (rst_n),
    .pll_lock  (pll_lock),
    .hi_en     (state_q == S_WAIT_LOCK),
    .lo_en     ((state_q == S_RELEASE) || (state_q == S_RUN)),
    .lock_good (lock_good),
    .lock_lost (lock_lost)
  );

  // Next-state decision; restart is ignored while already in RESET so the pulse is not stretched.
  always_comb begin
    state_nxt = state_q;
    timeout   = 1'b0;
    unique case (state_q)
      S_RESET: begin
        if (cyc_cnt == RST_LAST) state_nxt = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        timeout = (cyc_cnt == TMO_LAST) && !lock_good;
        if (restart || timeout) state_nxt = S_RESET;
        else if (lock_good)     state_nxt = S_RELEASE;
      end
      S_RELEASE: begin
        if (restart || lock_lost)     state_nxt = S_RESET;
        else if (cyc_cnt == REL_DONE) state_nxt = S_RUN;
      end
      S_RUN: begin
        if (restart || lock_lost) state_nxt = S_RESET;
      end
      default: state_nxt = S_RESET;
    endcase
    // A loss or timeout counts once even if restart arrives in the same cycle.
    relock_inc = timeout || lock_lost;
  end

  // Counter and channel-release values for the cycle after the coming edge.
  always_comb begin
    if ((state_nxt != state_q) || (state_nxt == S_RUN)) cnt_nxt = '0;
    else                                                 cnt_nxt = cyc_cnt + 1'b1;
    ch_nxt = '0;
    if (state_nxt == S_RUN) begin
      ch_nxt = '1;
    end else if (state_nxt == S_RELEASE) begin
      for (int k = 0; k < NUM_CH; k++) ch_nxt[k] = (cnt_nxt >= CW'((k + 1) * STAGGER));
    end
  end

  // State, cycle counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_RESET;
      cyc_cnt   <= '0;
      pll_rst   <= 1'b1;
      ch_rst_n  <= '0;
      all_ready <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      cyc_cnt   <= cnt_nxt;
      pll_rst   <= (state_nxt == S_RESET);
      ch_rst_n  <= ch_nxt;
      all_ready <= (state_nxt == S_RUN);
    end
  end

  // Saturating count of lock losses and lock timeouts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      relock_cnt <= '0;
    end else if (relock_inc && (relock_cnt != 8'hFF)) begin
      relock_cnt <= relock_cnt + 1'b1;
    end
  end

  assign state = state_q;

endmodule
